// File: rtl/check_move.sv
// Registered Connect-4 move-legality checker: decides whether a disc can drop into
// the selected column and reports the landing row and flattened cell index.
module check_move #(
    parameter int NUM_COLS = 7,
    parameter int NUM_ROWS = 6,
    parameter int COL_W    = 3,
    parameter int CELL_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [COL_W-1:0]  sel_col,
    input  logic [COL_W-1:0]  col0_cap,
    input  logic [COL_W-1:0]  col1_cap,
    input  logic [COL_W-1:0]  col2_cap,
    input  logic [COL_W-1:0]  col3_cap,
    input  logic [COL_W-1:0]  col4_cap,
    input  logic [COL_W-1:0]  col5_cap,
    input  logic [COL_W-1:0]  col6_cap,
    output logic              valid_move,
    output logic              invalid_move,
    output logic              done,
    output logic [COL_W-1:0]  target_row,
    output logic [CELL_W-1:0] target_cell,
    output logic [1:0]        err_code,
    output logic              board_full
);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_FULL = 2'b01;
    localparam logic [1:0] ERR_COL  = 2'b10;

    // Counts above NUM_ROWS (e.g. 7) are treated as full, never as wrap-around.
    function automatic logic col_full(input logic [COL_W-1:0] cap);
        return cap >= COL_W'(NUM_ROWS);
    endfunction

    // Widen both operands before multiplying so 7*cap never truncates.
    function automatic logic [CELL_W-1:0] cell_index(input logic [COL_W-1:0] col,
                                                     input logic [COL_W-1:0] row);
        return CELL_W'(row) * CELL_W'(NUM_COLS) + CELL_W'(col);
    endfunction

    logic [COL_W-1:0] cap_p0;
    logic             bad_col_p0;
    logic             col_full_p0;
    logic             board_full_p0;

    always_comb begin
        cap_p0 = '0;
        case (sel_col)
            3'd0:    cap_p0 = col0_cap;
            3'd1:    cap_p0 = col1_cap;
            3'd2:    cap_p0 = col2_cap;
            3'd3:    cap_p0 = col3_cap;
            3'd4:    cap_p0 = col4_cap;
            3'd5:    cap_p0 = col5_cap;
            3'd6:    cap_p0 = col6_cap;
            default: cap_p0 = '0;
        endcase
    end

    assign bad_col_p0    = sel_col > COL_W'(NUM_COLS - 1);
    assign col_full_p0   = col_full(cap_p0);
    assign board_full_p0 = col_full(col0_cap) & col_full(col1_cap) & col_full(col2_cap)
                         & col_full(col3_cap) & col_full(col4_cap) & col_full(col5_cap)
                         & col_full(col6_cap);

    // ---- stage 0 -> stage 1: registered result ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_move   <= 1'b0;
            invalid_move <= 1'b0;
            done         <= 1'b0;
            target_row   <= '0;
            target_cell  <= '0;
            err_code     <= ERR_OK;
            board_full   <= 1'b0;
        end else begin
            valid_move   <= 1'b0;
            invalid_move <= 1'b0;
            done         <= 1'b0;
            board_full   <= board_full_p0;
            if (req) begin
                done <= 1'b1;
                if (bad_col_p0) begin
                    invalid_move <= 1'b1;
                    err_code     <= ERR_COL;
                end else if (col_full_p0) begin
                    invalid_move <= 1'b1;
                    err_code     <= ERR_FULL;
                end else begin
                    valid_move   <= 1'b1;
                    err_code     <= ERR_OK;
                    target_row   <= cap_p0;
                    target_cell  <= cell_index(sel_col, cap_p0);
                end
            end
        end
    end

endmodule

// File: tb/tb_check_move.sv
// Self-checking bench for check_move: expected outputs are queued when a request is
// driven and compared one cycle later, plus explicit constants from the test plan.
module tb_check_move;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [2:0] sel_col = 3'd0;
    logic [2:0] cap [7];
    logic       valid_move, invalid_move, done, board_full;
    logic [2:0] target_row;
    logic [5:0] target_cell;
    logic [1:0] err_code;

    // {valid, invalid, done, row[2:0], cell[5:0], err[1:0], board_full}
    typedef logic [14:0] out_t;
    out_t sb [$];
    out_t exp_v;

    logic [2:0] m_row;
    logic [5:0] m_cell;
    logic [1:0] m_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    check_move dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .sel_col      (sel_col),
        .col0_cap     (cap[0]),
        .col1_cap     (cap[1]),
        .col2_cap     (cap[2]),
        .col3_cap     (cap[3]),
        .col4_cap     (cap[4]),
        .col5_cap     (cap[5]),
        .col6_cap     (cap[6]),
        .valid_move   (valid_move),
        .invalid_move (invalid_move),
        .done         (done),
        .target_row   (target_row),
        .target_cell  (target_cell),
        .err_code     (err_code),
        .board_full   (board_full)
    );

    function automatic out_t obs();
        return {valid_move, invalid_move, done, target_row, target_cell, err_code, board_full};
    endfunction

    task automatic model_reset();
        m_row  = 3'd0;
        m_cell = 6'd0;
        m_err  = 2'b00;
        sb.delete();
    endtask

    // Drive one request slot and queue what the outputs must show after the next edge.
    task automatic push_req(input logic r, input logic [2:0] s);
        logic v, iv, full;
        int c;
        req = r;
        sel_col = s;
        v = 1'b0;
        iv = 1'b0;
        full = 1'b1;
        for (int i = 0; i < 7; i++) if (cap[i] < 3'd6) full = 1'b0;
        if (r) begin
            if (s >= 3'd7) begin
                iv = 1'b1;
                m_err = 2'b10;
            end else begin
                c = int'(cap[s]);
                if (c >= 6) begin
                    iv = 1'b1;
                    m_err = 2'b01;
                end else begin
                    v = 1'b1;
                    m_err = 2'b00;
                    m_row = 3'(c);
                    m_cell = 6'(int'(s) + 7 * c);
                end
            end
        end
        sb.push_back({v, iv, v | iv, m_row, m_cell, m_err, full});
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) cap[i] = 3'd0;
        rst = 1'b0;
        req = 1'b0;
        cycle();
        cycle();
        total++;
        if (obs() !== 15'd0) $display("FAIL reset_idle: got %h want %h", obs(), 15'd0);
        else passed++;
        req = 1'b1;
        sel_col = 3'd3;
        cycle();
        total++;
        if (obs() !== 15'd0) $display("FAIL reset_ignores_req: got %h want %h", obs(), 15'd0);
        else passed++;
        rst = 1'b1;
        model_reset();
        push_req(1'b0, 3'd0);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL after_reset_idle: got %h want %h", obs(), exp_v);
        else passed++;
    endtask

    task automatic test_empty_move();
        push_req(1'b1, 3'd3);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL empty_move: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (target_cell !== 6'd3 || valid_move !== 1'b1 || done !== 1'b1)
            $display("FAIL empty_move_cell: got cell=%0d valid=%b done=%b want cell=3 valid=1 done=1",
                     target_cell, valid_move, done);
        else passed++;
        push_req(1'b0, 3'd3);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL empty_move_hold: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (valid_move !== 1'b0 || target_cell !== 6'd3)
            $display("FAIL pulse_one_cycle: got valid=%b cell=%0d want valid=0 cell=3", valid_move, target_cell);
        else passed++;
    endtask

    task automatic test_stacked();
        cap[4] = 3'd5;
        push_req(1'b1, 3'd4);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL stacked_col4: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (target_row !== 3'd5 || target_cell !== 6'd39)
            $display("FAIL stacked_col4_cell: got row=%0d cell=%0d want row=5 cell=39", target_row, target_cell);
        else passed++;
        cap[6] = 3'd5;
        push_req(1'b1, 3'd6);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL stacked_col6: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (target_cell !== 6'd41) $display("FAIL max_cell: got %0d want 41", target_cell);
        else passed++;
    endtask

    task automatic test_full_and_bad();
        cap[0] = 3'd6;
        push_req(1'b1, 3'd0);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL col_full: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (invalid_move !== 1'b1 || err_code !== 2'b01 || target_cell !== 6'd41)
            $display("FAIL col_full_fields: got inv=%b err=%b cell=%0d want inv=1 err=01 cell=41",
                     invalid_move, err_code, target_cell);
        else passed++;
        cap[2] = 3'd7;
        push_req(1'b1, 3'd2);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL count7_full: got %h want %h", obs(), exp_v);
        else passed++;
        push_req(1'b1, 3'd7);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL bad_col: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (invalid_move !== 1'b1 || err_code !== 2'b10)
            $display("FAIL bad_col_err: got inv=%b err=%b want inv=1 err=10", invalid_move, err_code);
        else passed++;
    endtask

    task automatic test_isolation();
        for (int i = 0; i < 7; i++) cap[i] = 3'd6;
        cap[5] = 3'd2;
        push_req(1'b1, 3'd5);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL other_cols_full: got %h want %h", obs(), exp_v);
        else passed++;
        total++;
        if (target_cell !== 6'd19 || board_full !== 1'b0)
            $display("FAIL other_cols_cell: got cell=%0d full=%b want cell=19 full=0", target_cell, board_full);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        for (int i = 0; i < 7; i++) cap[i] = 3'd6;
        cap[5] = 3'd7;
        push_req(1'b0, 3'd0);
        cycle();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v || board_full !== 1'b1)
            $display("FAIL board_full: got %h want %h", obs(), exp_v);
        else passed++;
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            push_req(1'b1, 3'(k));
            cycle();
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) $display("FAIL b2b_req%0d: got %h want %h", k, obs(), exp_v);
            else passed++;
            if (done && invalid_move && err_code == 2'b01) pulses++;
        end
        total++;
        if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses);
        else passed++;
        req = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) cap[i] = 3'd0;
        cycle();
        sb.delete();
        push_req(1'b1, 3'd2);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL pre_reset_move: got %h want %h", obs(), exp_v);
        else passed++;
        #1 rst = 1'b0;
        #1;
        total++;
        if (obs() !== 15'd0) $display("FAIL async_clear: got %h want %h", obs(), 15'd0);
        else passed++;
        @(negedge clk);
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || valid_move !== 1'b0)
            $display("FAIL no_pulse_in_reset: got done=%b valid=%b want 0 0", done, valid_move);
        else passed++;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_empty_move();
        test_stacked();
        test_full_and_bad();
        test_isolation();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/check_move.md
Name: check_move

Overview:
- Registered move-legality checker for the 7-column × 6-row Connect-4 controller.
- Takes the player's selected column and the seven per-column fill counts, then decides whether a disc can be dropped there.
- On a legal move, also reports the landing row and the flattened board-cell index (row-major, 7 cells per row, cell 0 = bottom-left).
- Sits between the column-select FSM and the board-write logic of the game controller.

Parameters:
- NUM_COLS, 7, number of board columns; legal column indices are 0..NUM_COLS-1.
- NUM_ROWS, 6, column capacity; a column is full when its count is ≥ NUM_ROWS.
- COL_W, 3, width of the column index and of each fill count.
- CELL_W, 6, width of the flattened cell index (covers 0..41).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  move request strobe; sampled on rising clk.
- sel_col  in  3  selected column index.
- col0_cap..col6_cap  in  3 each  current disc count of columns 0..6.
- valid_move  out  1  one-cycle pulse: the request was legal.
- invalid_move  out  1  one-cycle pulse: the request was illegal.
- done  out  1  one-cycle pulse: a result is present (valid_move OR invalid_move).
- target_row  out  3  landing row of the last legal move.
- target_cell  out  6  landing cell of the last legal move, equal to sel_col + 7*cap.
- err_code  out  2  reason for the last result: 00 ok, 01 column full, 10 bad column index.
- board_full  out  1  registered flag: all seven counts ≥ NUM_ROWS.

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0. Outputs stay at 0 while rst is low; req is ignored during reset.
- Latency: one cycle. req sampled high at edge N gives its result on the registered outputs after edge N, and they are visible for exactly one cycle.
- No handshake: every cycle with req=1 is an independent request. Back-to-back requests yield back-to-back done pulses. There is no busy state.
- Cycle with req=0: done, valid_move and invalid_move are 0. target_row, target_cell and err_code hold their previous values.
- Decision with req=1, cap = count of sel_col:
  - sel_col ≥ 7: invalid_move=1, err_code=10. target_* unchanged.
  - Otherwise, cap ≥ 6: invalid_move=1, err_code=01. target_* unchanged. Counts of 7 are treated as full, never as wrap-around.
  - Otherwise: valid_move=1, err_code=00, target_row=cap, target_cell=sel_col+7*cap.
- Arithmetic: the 7*cap product is computed at ≥ CELL_W bits, with no truncation. Maximum legal cell is 6+7*5=41.
- board_full: re-evaluated every cycle regardless of req, registered, 1 when every count ≥ 6.
  - A request while board_full=1 still gets a per-column result, i.e. err_code=01 for any legal index.
- valid_move and invalid_move are mutually exclusive. done = valid_move | invalid_move in the same cycle.
- Only the count of sel_col affects the decision; the other counts affect board_full only.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.
- Reset asserted mid-request: the pending result is discarded and all outputs clear immediately.
- Checking the move and updating the counts are separate jobs: the block never modifies counts; the caller increments the column count on valid_move.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then req=0 → all outputs 0; board_full=0 with all counts 0.
- Empty board legal move: all counts 0, sel_col=3, req=1 for one cycle → next cycle valid_move=1, done=1, err_code=00, target_row=0, target_cell=3. The following cycle valid_move=0 and target_cell stays 3.
- Stacked move: col4_cap=5, sel_col=4, req=1 → valid_move=1, target_row=5, target_cell=39. Then col6_cap=5, sel_col=6 → target_cell=41.
- Full column and bad index:
  - col0_cap=6, sel_col=0 → invalid_move=1, err_code=01, target_cell unchanged.
  - col2_cap=7, sel_col=2 → err_code=01.
  - sel_col=7 → invalid_move=1, err_code=10.
- Board full and back-to-back: all counts=6 → board_full=1 next cycle. Then req=1 for 3 consecutive cycles with sel_col=1,2,3 → three consecutive invalid_move pulses with err_code=01.
- Async reset mid-operation: a valid request sampled, rst pulled low before the next edge → valid_move, done and target_* read 0 immediately, with no result pulse emitted.
